// File: rtl/link_sipo_full.sv
// link_sipo_full: serial-in, parallel-out gearbox for the core-clock side of a DDR link receiver.
// Gathers els_p consecutive width_p-bit words from a valid/ready stream and presents them as a
// single els_p*width_p-bit word on a valid/yumi output. Each lane is a 2-entry FIFO, so the next
// packet can be gathered while the previous one waits for the consumer.
//
// Ports:
//   clk_i      core clock, rising-edge
//   reset_n_i  asynchronous active-low reset
//   v_i        input word valid
//   ready_o    a word can be accepted this cycle (registered state only)
//   data_i     serial input word
//   v_o        a full parallel word is available
//   data_o     parallel output word (concatenated lane heads)
//   yumi_i     consumer takes data_o this cycle; legal only while v_o=1
module link_sipo_full #(
   parameter int unsigned width_p    = 8,
   parameter int unsigned els_p      = 4,
   parameter bit          hi_to_lo_p = 1'b0
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       v_i,
   output logic                       ready_o,
   input  logic [width_p-1:0]         data_i,
   output logic                       v_o,
   output logic [els_p*width_p-1:0]   data_o,
   input  logic                       yumi_i
);

   localparam int unsigned IdxW = (els_p > 1) ? $clog2(els_p) : 1;

   logic [width_p-1:0] mem_q [els_p][2];
   logic [width_p-1:0] mem_d [els_p][2];
   logic [1:0]         cnt_q [els_p];
   logic [1:0]         cnt_d [els_p];
   logic [els_p-1:0]   rd_q, rd_d;
   logic [els_p-1:0]   wr_q, wr_d;
   logic [IdxW-1:0]    wr_idx_q, wr_idx_d;

   logic [els_p-1:0]   full;
   logic [els_p-1:0]   empty;
   logic [els_p-1:0]   enq;
   logic               accept;
   logic               deq;

   always_comb begin
      full  = '0;
      empty = '0;
      for (int k = 0; k < els_p; k++) begin
         full[k]  = (cnt_q[k] == 2'd2);
         empty[k] = (cnt_q[k] == 2'd0);
      end
   end

   assign ready_o = ~full[wr_idx_q];
   assign v_o     = ~|empty;
   assign accept  = v_i & ready_o;
   // An illegal yumi (v_o=0) is dropped here so it cannot corrupt lane state.
   assign deq     = yumi_i & v_o;

   always_comb begin
      mem_d    = mem_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      wr_idx_d = wr_idx_q;
      enq      = '0;
      for (int k = 0; k < els_p; k++) begin
         enq[k] = accept & (wr_idx_q == IdxW'(k));
         if (enq[k]) begin
            mem_d[k][wr_q[k]] = data_i;
            wr_d[k]           = ~wr_q[k];
         end
         if (deq) begin
            rd_d[k] = ~rd_q[k];
         end
         // Enqueue and dequeue in the same cycle leave the count unchanged.
         cnt_d[k] = cnt_q[k] + {1'b0, enq[k]} - {1'b0, deq};
      end
      if (accept) begin
         if (wr_idx_q == IdxW'(els_p - 1)) begin
            wr_idx_d = '0;
         end else begin
            wr_idx_d = wr_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int k = 0; k < els_p; k++) begin
            mem_q[k][0] <= '0;
            mem_q[k][1] <= '0;
            cnt_q[k]    <= '0;
         end
         rd_q     <= '0;
         wr_q     <= '0;
         wr_idx_q <= '0;
      end else begin
         mem_q    <= mem_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         wr_idx_q <= wr_idx_d;
      end
   end

   always_comb begin
      data_o = '0;
      for (int k = 0; k < els_p; k++) begin
         if (hi_to_lo_p) begin
            data_o[(els_p-1-k)*width_p +: width_p] = mem_q[k][rd_q[k]];
         end else begin
            data_o[k*width_p +: width_p] = mem_q[k][rd_q[k]];
         end
      end
   end

   yumi_only_when_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      yumi_i |-> v_o)
      else $error("link_sipo_full: yumi_i asserted while v_o=0");

endmodule

// File: tb/tb_link_sipo_full.sv
module tb_link_sipo_full;
   localparam int unsigned W  = 8;
   localparam int unsigned E  = 4;
   localparam int unsigned DW = W * E;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          v_i;
   logic          yumi_i;
   logic [W-1:0]  data_i;
   logic          ready0, v0, ready1, v1;
   logic [DW-1:0] data0, data1;

   int errors = 0;
   int checks = 0;
   int pops   = 0;

   logic [DW-1:0] sb_lo [$];
   logic [DW-1:0] sb_hi [$];
   logic [W-1:0]  part  [$];

   always #5 clk_i = ~clk_i;

   link_sipo_full #(.width_p(W), .els_p(E), .hi_to_lo_p(1'b0)) dut_lo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (v_i),
      .ready_o   (ready0),
      .data_i    (data_i),
      .v_o       (v0),
      .data_o    (data0),
      .yumi_i    (yumi_i)
   );

   link_sipo_full #(.width_p(W), .els_p(E), .hi_to_lo_p(1'b1)) dut_hi (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (v_i),
      .ready_o   (ready1),
      .data_i    (data_i),
      .v_o       (v1),
      .data_o    (data1),
      .yumi_i    (yumi_i)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: accumulate accepted words into packets in arrival order.
   task automatic model_push(input logic [W-1:0] d);
      logic [DW-1:0] lo, hi;
      part.push_back(d);
      if (part.size() == E) begin
         lo = '0;
         hi = '0;
         for (int k = 0; k < E; k++) begin
            lo[k*W +: W]       = part[k];
            hi[(E-1-k)*W +: W] = part[k];
         end
         sb_lo.push_back(lo);
         sb_hi.push_back(hi);
         part.delete();
      end
   endtask

   // One cycle: drive at the negedge, compare any popped word, advance to the next negedge.
   task automatic step(input logic v, input logic [W-1:0] d, input logic y, output logic acc);
      v_i    = v;
      data_i = d;
      yumi_i = y;
      acc    = v & ready0;
      if (y) begin
         chk("v_o_at_yumi", DW'(v0), DW'(1));
         chk("v_o_hi_at_yumi", DW'(v1), DW'(1));
         if (sb_lo.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow observed=pop expected=empty_queue");
         end else begin
            chk("data_lo", data0, sb_lo.pop_front());
            chk("data_hi", data1, sb_hi.pop_front());
            pops++;
         end
      end
      if (acc) model_push(d);
      @(posedge clk_i);
      @(negedge clk_i);
      v_i    = 1'b0;
      yumi_i = 1'b0;
   endtask

   initial begin
      logic acc;
      int   guard;
      reset_n_i = 1'b0;
      v_i       = 1'b0;
      yumi_i    = 1'b0;
      data_i    = '0;
      @(negedge clk_i);
      chk("rst_v_o", DW'(v0), DW'(0));
      chk("rst_ready_o", DW'(ready0), DW'(1));
      chk("rst_data_o", data0, '0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      step(1'b0, 8'h00, 1'b0, acc);
      step(1'b0, 8'h00, 1'b0, acc);
      chk("idle_v_o", DW'(v0), DW'(0));
      chk("idle_ready_o", DW'(ready0), DW'(1));
      chk("idle_data_o", data0, '0);

      // Single packet.
      step(1'b1, 8'h11, 1'b0, acc);
      step(1'b1, 8'h22, 1'b0, acc);
      step(1'b1, 8'h33, 1'b0, acc);
      chk("pkt_v_o_early", DW'(v0), DW'(0));
      step(1'b1, 8'h44, 1'b0, acc);
      chk("pkt_acc4", DW'(acc), DW'(1));
      chk("pkt_v_o", DW'(v0), DW'(1));
      chk("pkt_data_lo", data0, 32'h44332211);
      chk("pkt_data_hi", data1, 32'h11223344);
      step(1'b0, 8'h00, 1'b1, acc);
      chk("pkt_v_o_after_yumi", DW'(v0), DW'(0));

      // Backpressure: two packets fill every lane.
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, W'(i), 1'b0, acc);
         chk("bp_accept", DW'(acc), DW'(1));
      end
      chk("bp_data_first", data0, 32'h04030201);
      chk("bp_ready_full", DW'(ready0), DW'(0));
      step(1'b1, 8'h09, 1'b0, acc);
      chk("bp_9_rejected", DW'(acc), DW'(0));
      step(1'b1, 8'h09, 1'b1, acc);
      chk("bp_9_rejected_yumi", DW'(acc), DW'(0));
      chk("bp_ready_back", DW'(ready0), DW'(1));
      chk("bp_data_second", data0, 32'h08070605);
      step(1'b1, 8'h09, 1'b0, acc);
      chk("bp_9_accepted", DW'(acc), DW'(1));
      step(1'b0, 8'h00, 1'b1, acc);
      step(1'b1, 8'h0A, 1'b0, acc);
      step(1'b1, 8'h0B, 1'b0, acc);
      step(1'b1, 8'h0C, 1'b0, acc);
      chk("bp_data_third", data0, 32'h0C0B0A09);
      step(1'b0, 8'h00, 1'b1, acc);
      chk("bp_drained", DW'(v0), DW'(0));

      // Streaming with yumi_i following v_o.
      pops = 0;
      for (int i = 0; i < 64; i++) begin
         if (i == 4) chk("stream_first", data0, 32'h03020100);
         step(1'b1, W'(i), v0, acc);
         chk("stream_accept", DW'(acc), DW'(1));
      end
      guard = 0;
      while (v0 && guard < 8) begin
         step(1'b0, 8'h00, 1'b1, acc);
         guard++;
      end
      chk("stream_pops", DW'(pops), DW'(16));
      chk("stream_sb_empty", DW'(sb_lo.size()), DW'(0));

      // Reset asserted mid-packet while a full word is presented.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, W'(8'hE0 + i), 1'b0, acc);
      end
      chk("mid_v_o_before", DW'(v0), DW'(1));
      #2;
      reset_n_i = 1'b0;
      #1;
      chk("async_rst_v_o", DW'(v0), DW'(0));
      chk("async_rst_ready_o", DW'(ready0), DW'(1));
      chk("async_rst_data_o", data0, '0);
      sb_lo.delete();
      sb_hi.delete();
      part.delete();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, W'(8'hA0 + i), 1'b0, acc);
      end
      chk("post_rst_data_lo", data0, 32'hA3A2A1A0);
      chk("post_rst_data_hi", data1, 32'hA0A1A2A3);
      step(1'b0, 8'h00, 1'b1, acc);
      chk("post_rst_v_o", DW'(v0), DW'(0));
      chk("post_rst_sb_empty", DW'(sb_lo.size()), DW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
